// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache level.
package cache_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_WAIT,
    ST_RESPOND,
    ST_FLUSH
  } state_t;

  // Widest block the word-select helper can handle
  localparam int MAX_BLOCK = 2048;

  function automatic int calc_sets(input int size, input int block_size, input int assoc);
    return (size * 8) / (block_size * assoc);
  endfunction

  function automatic int calc_offset(input int block_size);
    return $clog2(block_size / 8);
  endfunction

  function automatic int calc_index(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag(input int addr_width, input int offset, input int index);
    return addr_width - offset - index;
  endfunction

  // Way pointer width; a direct-mapped cache still carries a 1-bit pointer
  function automatic int calc_way_bits(input int assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

  // Picks the 32-bit word addressed by byte_addr out of a block. The word
  // index is byte_addr[offset_bits-1:2]; with 4-byte blocks the mask is zero
  // and word 0 is always returned.
  function automatic logic [31:0] select_word(input logic [MAX_BLOCK-1:0] blk,
                                              input logic [31:0] byte_addr,
                                              input int offset_bits);
    logic [31:0]          word_mask;
    logic [31:0]          word_idx;
    logic [MAX_BLOCK-1:0] shifted;
    word_mask = (32'd1 << (offset_bits - 2)) - 32'd1;
    word_idx  = (byte_addr >> 2) & word_mask;
    shifted   = blk >> (word_idx * 32'd32);
    return shifted[31:0];
  endfunction

endpackage

// File: rtl/cache_set_rr.sv
// One cache set: valid bits, tags, data blocks and a round-robin victim pointer.
module cache_set_rr
  import cache_pkg::*;
#(
  parameter int ASSOCIATIVITY = 2,
  parameter int TAG_WIDTH     = 4,
  parameter int BLOCK_SIZE    = 64,
  localparam int WAY_W        = calc_way_bits(ASSOCIATIVITY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  invalidate,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  hit,
  output logic [WAY_W-1:0]      hit_way,
  input  logic [WAY_W-1:0]      rd_way,
  output logic [BLOCK_SIZE-1:0] rd_block,
  input  logic                  fill_en,
  input  logic [TAG_WIDTH-1:0]  fill_tag,
  input  logic [BLOCK_SIZE-1:0] fill_data
);

  logic [ASSOCIATIVITY-1:0] valid_reg;
  logic [WAY_W-1:0]         rr_ptr_reg;
  logic [TAG_WIDTH-1:0]     tag_mem  [ASSOCIATIVITY];
  logic [BLOCK_SIZE-1:0]    data_mem [ASSOCIATIVITY];
  logic [ASSOCIATIVITY-1:0] way_match;

  genvar gi;
  generate
    for (gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_match
      assign way_match[gi] = valid_reg[gi] && (tag_mem[gi] == lookup_tag);
    end
  endgenerate

  // Encode the matching way; at most one way can match
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (way_match[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign rd_block = data_mem[rd_way];

  // Tag and data storage: written on fill only, never reset
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[rr_ptr_reg]  <= fill_tag;
      data_mem[rr_ptr_reg] <= fill_data;
    end
  end

  // Valid bits and victim pointer: cleared by reset or invalidate, advanced on fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg  <= '0;
      rr_ptr_reg <= '0;
    end else if (invalidate) begin
      valid_reg  <= '0;
      rr_ptr_reg <= '0;
    end else if (fill_en) begin
      valid_reg[rr_ptr_reg] <= 1'b1;
      if (rr_ptr_reg == WAY_W'(ASSOCIATIVITY - 1)) begin
        rr_ptr_reg <= '0;
      end else begin
        rr_ptr_reg <= rr_ptr_reg + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_level.sv
// Read-only set-associative cache level with programmable lookup delay,
// block fill from the level below and saturating hit/miss statistics.
module cache_level
  import cache_pkg::*;
#(
  parameter int SIZE          = 1024,
  parameter int BLOCK_SIZE    = 64,
  parameter int ASSOCIATIVITY = 2,
  parameter int DELAY         = 4,
  parameter int ADDR_WIDTH    = 12,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  ready_out,
  output logic                  resp_valid,
  output logic [31:0]           data_out,
  output logic                  hit_out,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_valid_in,
  input  logic [BLOCK_SIZE-1:0] mem_data_in,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int SETS   = calc_sets(SIZE, BLOCK_SIZE, ASSOCIATIVITY);
  localparam int OFFSET = calc_offset(BLOCK_SIZE);
  localparam int INDEX  = calc_index(SETS);
  localparam int TAG    = calc_tag(ADDR_WIDTH, OFFSET, INDEX);
  localparam int IDX_W  = (INDEX > 0) ? INDEX : 1;
  localparam int WAY_W  = calc_way_bits(ASSOCIATIVITY);
  localparam int DLY_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DLY_W-1:0]      dly_reg;
  logic                  resp_valid_reg;
  logic                  hit_out_reg;
  logic [31:0]           data_out_reg;
  logic                  mem_req_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [CNT_WIDTH-1:0]  hit_cnt_reg;
  logic [CNT_WIDTH-1:0]  miss_cnt_reg;

  logic [TAG-1:0]        req_tag;
  logic [IDX_W-1:0]      req_index;
  logic [SETS-1:0]       set_hit;
  logic [BLOCK_SIZE-1:0] set_block [SETS];
  logic                  lookup_hit;
  logic [31:0]           hit_word;
  logic [31:0]           fill_word;
  logic                  fill_active;
  logic                  invalidate_all;

  assign req_tag = addr_reg[ADDR_WIDTH-1 -: TAG];

  generate
    if (INDEX > 0) begin : g_index
      assign req_index = addr_reg[OFFSET +: INDEX];
    end else begin : g_no_index
      assign req_index = '0;
    end
  endgenerate

  assign fill_active    = (state_reg == ST_MISS_WAIT) && mem_valid_in;
  assign invalidate_all = (state_reg == ST_FLUSH);

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      logic [WAY_W-1:0] way_sel;
      cache_set_rr #(
        .ASSOCIATIVITY (ASSOCIATIVITY),
        .TAG_WIDTH     (TAG),
        .BLOCK_SIZE    (BLOCK_SIZE)
      ) u_set (
        .clk        (clk),
        .reset      (reset),
        .invalidate (invalidate_all),
        .lookup_tag (req_tag),
        .hit        (set_hit[gi]),
        .hit_way    (way_sel),
        .rd_way     (way_sel),
        .rd_block   (set_block[gi]),
        .fill_en    (fill_active && (req_index == IDX_W'(gi))),
        .fill_tag   (req_tag),
        .fill_data  (mem_data_in)
      );
    end
  endgenerate

  assign lookup_hit = set_hit[req_index];
  assign hit_word   = select_word(MAX_BLOCK'(set_block[req_index]), 32'(addr_reg), OFFSET);
  assign fill_word  = select_word(MAX_BLOCK'(mem_data_in), 32'(addr_reg), OFFSET);

  // Flush takes priority over a request, so the block looks busy that cycle
  assign ready_out    = (state_reg == ST_IDLE) && !flush;
  assign resp_valid   = resp_valid_reg;
  assign data_out     = data_out_reg;
  assign hit_out      = hit_out_reg;
  assign mem_req_out  = mem_req_reg;
  assign mem_addr_out = mem_addr_reg;
  assign hit_count    = hit_cnt_reg;
  assign miss_count   = miss_cnt_reg;

  // Controller: accept, delayed lookup, downstream fill, response and flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      dly_reg        <= '0;
      resp_valid_reg <= 1'b0;
      hit_out_reg    <= 1'b0;
      data_out_reg   <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          resp_valid_reg <= 1'b0;
          if (flush) begin
            state_reg <= ST_FLUSH;
          end else if (req_in) begin
            addr_reg  <= addr_in;
            dly_reg   <= DLY_W'(DELAY - 1);
            state_reg <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (dly_reg != '0) begin
            dly_reg <= dly_reg - DLY_W'(1);
          end else if (lookup_hit) begin
            data_out_reg   <= hit_word;
            hit_out_reg    <= 1'b1;
            resp_valid_reg <= 1'b1;
            if (hit_cnt_reg != {CNT_WIDTH{1'b1}}) begin
              hit_cnt_reg <= hit_cnt_reg + CNT_WIDTH'(1);
            end
            state_reg <= ST_RESPOND;
          end else begin
            if (miss_cnt_reg != {CNT_WIDTH{1'b1}}) begin
              miss_cnt_reg <= miss_cnt_reg + CNT_WIDTH'(1);
            end
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= {addr_reg[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            state_reg    <= ST_MISS_WAIT;
          end
        end
        ST_MISS_WAIT: begin
          if (mem_valid_in) begin
            mem_req_reg    <= 1'b0;
            data_out_reg   <= fill_word;
            hit_out_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        ST_FLUSH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_level.sv
// Directed bench for cache_level: miss/hit timing, replacement, flush,
// reset during a fill and counter saturation (2-bit counters).
module tb_cache_level;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_in;
  logic [11:0] addr_in;
  logic        ready_out;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        hit_out;
  logic        mem_req_out;
  logic [11:0] mem_addr_out;
  logic        mem_valid_in;
  logic [63:0] mem_data_in;
  logic [1:0]  hit_count;
  logic [1:0]  miss_count;

  int check_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [63:0] BLK_A = 64'hBBBB0001_AAAA0000;
  localparam logic [63:0] BLK_B = 64'h22220002_11110001;
  localparam logic [63:0] BLK_C = 64'h44440004_33330003;

  cache_level #(
    .SIZE          (512),
    .BLOCK_SIZE    (64),
    .ASSOCIATIVITY (2),
    .DELAY         (4),
    .ADDR_WIDTH    (12),
    .CNT_WIDTH     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_in       (req_in),
    .addr_in      (addr_in),
    .ready_out    (ready_out),
    .resp_valid   (resp_valid),
    .data_out     (data_out),
    .hit_out      (hit_out),
    .mem_req_out  (mem_req_out),
    .mem_addr_out (mem_addr_out),
    .mem_valid_in (mem_valid_in),
    .mem_data_in  (mem_data_in),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // One read transaction; a miss is served two cycles after mem_req_out rises
  task automatic read_word(input logic [11:0] addr, input logic [63:0] blk,
                           input logic exp_hit, input logic [31:0] exp_data);
    int n;
    int mem_wait;
    @(negedge clk);
    check("ready_idle", 64'(ready_out), 64'd1);
    req_in  = 1'b1;
    addr_in = addr;
    @(negedge clk);
    req_in   = 1'b0;
    mem_wait = 0;
    for (n = 0; n < 60; n++) begin
      if (resp_valid) break;
      if (mem_req_out) begin
        if (mem_wait == 0) check("mem_addr", 64'(mem_addr_out), 64'({addr[11:3], 3'b000}));
        if (mem_wait == 2) begin
          mem_valid_in = 1'b1;
          mem_data_in  = blk;
        end
        mem_wait++;
      end
      @(negedge clk);
    end
    mem_valid_in = 1'b0;
    check("resp_seen", 64'(n < 60), 64'd1);
    check("hit_out", 64'(hit_out), 64'(exp_hit));
    check("data_out", 64'(data_out), 64'(exp_data));
    if (exp_hit) begin
      check("hit_latency", 64'(n), 64'd4);
      check("hit_no_mem_req", 64'(mem_wait), 64'd0);
    end else begin
      check("fill_handshake", 64'(mem_wait), 64'd3);
      check("mem_req_dropped", 64'(mem_req_out), 64'd0);
    end
    $display("read addr=%03h data=%08h hit=%0d latency=%0d hits=%0d misses=%0d",
             addr, data_out, hit_out, n, hit_count, miss_count);
    @(negedge clk);
    check("resp_pulse", 64'(resp_valid), 64'd0);
    check("data_hold", 64'(data_out), 64'(exp_data));
  endtask

  initial begin
    int n;
    int pulses;
    reset        = 1'b1;
    flush        = 1'b0;
    req_in       = 1'b0;
    addr_in      = '0;
    mem_valid_in = 1'b0;
    mem_data_in  = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_hit_out", 64'(hit_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_mem_req", 64'(mem_req_out), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_out), 64'd0);
    check("rst_counts", 64'({hit_count, miss_count}), 64'd0);
    reset = 1'b1;

    // Cold miss, then hit on the other word of the same block
    read_word(12'h050, BLK_A, 1'b0, 32'hAAAA0000);
    check("miss_count_1", 64'(miss_count), 64'd1);
    read_word(12'h054, BLK_A, 1'b1, 32'hBBBB0001);
    check("hit_count_1", 64'(hit_count), 64'd1);

    // Conflicts in set 0x0A: 0x150 -> way1, 0x250 evicts way0 (0x050)
    read_word(12'h150, BLK_B, 1'b0, 32'h11110001);
    read_word(12'h250, BLK_C, 1'b0, 32'h33330003);
    check("miss_count_3", 64'(miss_count), 64'd3);
    read_word(12'h154, BLK_B, 1'b1, 32'h22220002);
    read_word(12'h050, BLK_A, 1'b0, 32'hAAAA0000);
    check("miss_count_sat", 64'(miss_count), 64'd3);
    check("hit_count_2", 64'(hit_count), 64'd2);

    // Flush with a simultaneous request: request must not be accepted
    @(negedge clk);
    flush   = 1'b1;
    req_in  = 1'b1;
    addr_in = 12'h250;
    #1 check("flush_ready_low", 64'(ready_out), 64'd0);
    @(negedge clk);
    flush  = 1'b0;
    req_in = 1'b0;
    check("flush_busy", 64'(ready_out), 64'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || mem_req_out) pulses++;
    end
    check("flush_no_accept", 64'(pulses), 64'd0);
    check("flush_ready_back", 64'(ready_out), 64'd1);
    $display("flush done hits=%0d misses=%0d", hit_count, miss_count);
    read_word(12'h150, BLK_B, 1'b0, 32'h11110001);

    // Reset while waiting on the level below
    @(negedge clk);
    req_in  = 1'b1;
    addr_in = 12'h3A0;
    @(negedge clk);
    req_in = 1'b0;
    n = 0;
    while (!mem_req_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_miss", 64'(mem_req_out), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_mem_req", 64'(mem_req_out), 64'd0);
    check("rst_hit_clear", 64'(hit_count), 64'd0);
    check("rst_miss_clear", 64'(miss_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready_after", 64'(ready_out), 64'd1);
    mem_valid_in = 1'b1;
    mem_data_in  = BLK_C;
    @(negedge clk);
    mem_valid_in = 1'b0;
    pulses = 0;
    repeat (6) begin
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    check("late_fill_ignored", 64'(pulses), 64'd0);
    $display("reset mid-miss done ready=%0d", ready_out);

    // Valid bits were cleared, so 0x050 misses; then five hits saturate at 3
    read_word(12'h050, BLK_A, 1'b0, 32'hAAAA0000);
    read_word(12'h054, BLK_A, 1'b1, 32'hBBBB0001);
    read_word(12'h050, BLK_A, 1'b1, 32'hAAAA0000);
    read_word(12'h054, BLK_A, 1'b1, 32'hBBBB0001);
    read_word(12'h050, BLK_A, 1'b1, 32'hAAAA0000);
    read_word(12'h054, BLK_A, 1'b1, 32'hBBBB0001);
    check("hit_count_sat", 64'(hit_count), 64'd3);
    check("miss_count_after", 64'(miss_count), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/cache_level.md
Name: cache_level

Overview:
- Parametrised, set-associative, read-only cache level with a programmable lookup delay.
- Accepts word read requests from the level above and returns a 32-bit word.
- On a miss, fetches a whole block from the level below, installs it with round-robin replacement, then responds.
- Instances chain into a hierarchy (L1 → L2 → memory model); hit and miss counters support hierarchy studies.

Parameters:
- SIZE, 1024: total data capacity in bytes.
- BLOCK_SIZE, 64: block width in bits; power of two, ≥ 32.
- ASSOCIATIVITY, 2: ways per set; power of two, ≥ 1.
- DELAY, 4: cycles from request accept to hit response; ≥ 1.
- ADDR_WIDTH, 12: byte address width; must exceed offset + index bits.
- CNT_WIDTH, 16: width of the hit and miss counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- req_in  in  1  upstream request valid.
- addr_in  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- ready_out  out  1  block can accept req_in this cycle.
- resp_valid  out  1  one-cycle pulse; data_out valid.
- data_out  out  32  requested word.
- hit_out  out  1  qualifies resp_valid: 1 = hit, 0 = filled after miss.
- mem_req_out  out  1  downstream block request, level-held.
- mem_addr_out  out  ADDR_WIDTH  block-aligned miss address; offset bits = 0.
- mem_valid_in  in  1  downstream block data valid.
- mem_data_in  in  BLOCK_SIZE  downstream block data.
- hit_count  out  CNT_WIDTH  saturating hit counter.
- miss_count  out  CNT_WIDTH  saturating miss counter.

Behaviour:
- Address geometry:
  - SETS = SIZE*8/(BLOCK_SIZE*ASSOCIATIVITY).
  - OFFSET = log2(BLOCK_SIZE/8); INDEX = log2(SETS); TAG = ADDR_WIDTH-OFFSET-INDEX.
  - Word select = addr[OFFSET-1:2]; zero-width when BLOCK_SIZE = 32 (single word).
- Reset (reset = 0, asynchronous):
  - All valid bits cleared; round-robin pointers = 0; counters = 0; FSM = IDLE.
  - ready_out = 1 and resp_valid = 0; hit_out = 0, data_out = 0.
  - mem_req_out = 0, mem_addr_out = 0.
  - Tag and data arrays are not reset.
  - Reset mid-miss abandons the fill; a late mem_valid_in in IDLE is ignored.
- FSM states: IDLE, LOOKUP, MISS_WAIT, RESPOND, FLUSH.
- IDLE:
  - ready_out = 1.
  - flush = 1 → FLUSH, with ready_out = 0 that cycle. Flush wins over a simultaneous req_in, which is not accepted.
  - Otherwise req_in = 1 → latch the address, load the delay counter with DELAY-1, → LOOKUP.
- LOOKUP:
  - ready_out = 0; the counter decrements each cycle.
  - When the counter is 0, compare the tag against all ways of the indexed set; hit requires valid && tag match.
  - Hit → RESPOND with the way's word; increment hit_count.
  - Miss → MISS_WAIT; increment miss_count; the victim is the set's round-robin pointer.
  - Hit response is therefore asserted exactly DELAY cycles after the accept edge.
- MISS_WAIT:
  - mem_req_out = 1 and mem_addr_out = {tag, index, 0}, both held steady.
  - On mem_valid_in: write the victim way's data and tag, set valid, pointer = (pointer+1) mod ASSOCIATIVITY, drop mem_req_out next cycle → RESPOND with the word taken from mem_data_in.
  - No timeout.
- RESPOND:
  - resp_valid = 1 for one cycle, with data_out and hit_out → IDLE.
  - data_out holds its value until the next response.
- FLUSH:
  - Clears every valid bit and every pointer in one cycle → IDLE.
  - Counters are not cleared.
- Counters saturate at 2^CNT_WIDTH-1; no wrap.
- Duplicate tags in one set cannot occur: a fill only follows a miss on the same set.
- req_in asserted while ready_out = 0 is ignored. Upstream holds req_in until it sees ready_out = 1 in the same cycle.

Decomposition:
- Package cache_pkg:
  - FSM state enum.
  - Constant functions for SETS, OFFSET, INDEX and TAG widths, taking the parameters as arguments.
  - Word-select helper function.
- One natural sub-module: cache_set_rr. It holds one set's valid, tag and data arrays plus its round-robin pointer, and exposes the hit flag, hit way, read block and fill/invalidate ports.
- Top level: FSM, delay counter, stat counters, downstream handshake.

Test Plan (SIZE=512, BLOCK_SIZE=64, ASSOCIATIVITY=2, DELAY=4, ADDR_WIDTH=12; SETS=32, OFFSET=3, INDEX=5, TAG=4):
- Cold miss:
  - Stimulus: req 0x050; return mem_data_in = 0xBBBB0001_AAAA0000 two cycles after mem_req_out.
  - Required: mem_addr_out = 0x050; resp_valid with data_out = 0xAAAA0000, hit_out = 0; miss_count = 1.
- Hit timing and word select:
  - Stimulus: req 0x054.
  - Required: resp_valid exactly 4 cycles after accept; data_out = 0xBBBB0001, hit_out = 1; hit_count = 1; mem_req_out stays 0.
- Conflict and round-robin replacement:
  - Stimulus: fill 0x150 (way1), then 0x250.
  - Required: 0x250 evicts way0, i.e. the tag of 0x050. Re-requesting 0x050 misses; re-requesting 0x150 hits.
- Flush:
  - Stimulus: flush and req_in asserted together in IDLE.
  - Required: ready_out = 0 that cycle, request not accepted. Afterwards 0x150 misses with mem_addr_out = 0x150.
- Reset mid-miss:
  - Stimulus: drop reset while in MISS_WAIT.
  - Required: mem_req_out falls asynchronously; counters = 0; ready_out = 1 after release. A later mem_valid_in produces no resp_valid.
- Counter saturation:
  - Stimulus: CNT_WIDTH=2, issue 5 hits.
  - Required: hit_count = 3.
